// File: rtl/f3m_mult_ds.sv
// -----------------------------------------------------------------------------
// f3m_mult_ds
//
// Digit-serial multiplier over GF(3^M), polynomial basis,
// p(x) = x^M + x^K + 2.
//
// Each RUN cycle consumes D trits of the multiplier B and adds D shifted
// copies of A into the accumulator z. The design finishes in N = ceil(M/D)
// iterations. D trades area and combinational depth against latency.
//
// Trit encoding: 00 = 0, 01 = 1, 10 = 2. Trit i of an element sits in
// bits [2i+1:2i]. Canonical inputs always give a canonical C.
//
// Compile-time option:
//   F3M_MULT_ACC_EN : when defined, adds the ACC port and seeds z with ACC,
//                     so C = A*B + ACC mod p. When undefined, C = A*B mod p.
//
// Ports:
//   clk    in   1    rising-edge clock
//   reset  in   1    synchronous active-high reset; highest priority
//   start  in   1    start request, sampled only while idle
//   A      in   2M   multiplicand
//   B      in   2M   multiplier
//   ACC    in   2M   addend (only with F3M_MULT_ACC_EN)
//   C      out  2M   product register; holds its value between operations
//   busy   out  1    high while an operation runs (equivalent to state RUN)
//   done   out  1    one-cycle pulse; C is valid in that cycle
//
// Handshake: an operation is accepted on a rising edge where start = 1 and
// busy = 0. done pulses for exactly one cycle, N clocks after that edge, and
// busy is already low in the done cycle. start may be high in the done cycle,
// which gives one result every N+1 clocks. start seen while busy = 1 is
// ignored, and A/B/ACC are only sampled on the accepting edge.
// -----------------------------------------------------------------------------
module f3m_mult_ds #(
    parameter int M = 97,
    parameter int K = 12,
    parameter int D = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2*M-1:0]   A,
    input  logic [2*M-1:0]   B,
`ifdef F3M_MULT_ACC_EN
    input  logic [2*M-1:0]   ACC,
`endif
    output logic [2*M-1:0]   C,
    output logic             busy,
    output logic             done
);

    localparam int W  = 2 * M;
    localparam int N  = (M + D - 1) / D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // GF(3) trit arithmetic
    // -------------------------------------------------------------------------
    function automatic logic [1:0] t_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // For canonical operands: 1*1 = 2*2 = 1, 1*2 = 2*1 = 2.
    function automatic logic [1:0] t_mul(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] r;
        if (a == 2'd0 || b == 2'd0) begin
            r = 2'd0;
        end else if (a == b) begin
            r = 2'd1;
        end else begin
            r = 2'd2;
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // GF(3^M) element helpers
    // -------------------------------------------------------------------------
    function automatic logic [W-1:0] v_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            r[2*i +: 2] = t_add(a[2*i +: 2], b[2*i +: 2]);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] v_scale(input logic [W-1:0] a, input logic [1:0] s);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            r[2*i +: 2] = t_mul(a[2*i +: 2], s);
        end
        return r;
    endfunction

    // Multiply by X and reduce. The trit shifted out of position M-1 folds
    // back through X^M = 2*X^K + 1: it lands unchanged at trit 0 and doubled
    // at trit K. One fold is enough because only one trit overflows per shift.
    function automatic logic [W-1:0] v_mulx(input logic [W-1:0] a);
        logic [W-1:0] r;
        logic [1:0]   top;
        top = a[W-1 -: 2];
        r   = '0;
        for (int i = 1; i < M; i++) begin
            r[2*i +: 2] = a[2*(i-1) +: 2];
        end
        r[1:0]       = top;
        r[2*K +: 2]  = t_add(a[2*(K-1) +: 2], t_mul(2'd2, top));
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [W-1:0]    x_q, x_d;      // A * X^(D*iter) mod p
    logic [W-1:0]    y_q, y_d;      // remaining trits of B, low digit first
    logic [W-1:0]    z_q, z_d;      // running sum
    logic [W-1:0]    c_q, c_d;      // result register
    logic [CW-1:0]   cnt_q, cnt_d;  // iterations left after the current one
    logic            done_q, done_d;

    // One digit step: D chained scale-and-add terms, x advanced by X^D.
    logic [W-1:0]    xs;
    logic [W-1:0]    zs;

    always_comb begin
        xs = x_q;
        zs = z_q;
        for (int j = 0; j < D; j++) begin
            zs = v_add(zs, v_scale(xs, y_q[2*j +: 2]));
            xs = v_mulx(xs);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = A;
                    y_d     = B;
`ifdef F3M_MULT_ACC_EN
                    z_d     = ACC;
`else
                    z_d     = '0;
`endif
                    cnt_d   = CNT_LOAD;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = xs;
                // Zero fill keeps the trits past M-1 of the last digit at 0.
                y_d = y_q >> (2 * D);
                z_d = zs;
                if (cnt_q == '0) begin
                    c_d     = zs;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign C    = c_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule
